// File: rtl/poseidon_stream_adapter.sv
// Stream adapter between a packed {last, element} stream and the Poseidon core.
// Captures a per-message tag on the first beat, queues it in an in-order tag
// FIFO on the last beat, and reattaches it to each core result through a
// registered 2-entry skid buffer. Flags core results that arrive with no tag.
module poseidon_stream_adapter #(
    parameter int DATA_W         = 256,
    parameter int TAG_W          = 8,
    parameter int DEPTH          = 4,
    parameter int LAST_FROM_CORE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic [TAG_W-1:0]           s_tag,
    output logic                       core_in_valid,
    input  logic                       core_in_ready,
    output logic                       core_in_last,
    output logic [DATA_W-2:0]          core_in_payload,
    input  logic                       core_out_valid,
    output logic                       core_out_ready,
    input  logic                       core_out_last,
    input  logic [DATA_W-2:0]          core_out_payload,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [TAG_W-1:0]           m_tag,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       err_orphan
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Tag FIFO state
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Message tracking state
    logic             first_beat_q, first_beat_d;
    logic [TAG_W-1:0] held_tag_q, held_tag_d;
    logic             err_orphan_q, err_orphan_d;

    // Skid buffer: head drives the outputs, spare absorbs one extra result
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_data_q, head_data_d, spare_data_q, spare_data_d;
    logic [TAG_W-1:0]  head_tag_q, head_tag_d, spare_tag_q, spare_tag_d;

    logic              fifo_full, fifo_empty, blk;
    logic              s_fire, push, pop, out_fire, skid_has_space;
    logic [TAG_W-1:0]  tag_use;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;

    // Handshake, tag selection and result formatting; full/empty from registered state only
    always_comb begin
        fifo_full       = (count_q == CNT_W'(DEPTH));
        fifo_empty      = (count_q == '0);
        blk             = s_data[DATA_W-1] & fifo_full;
        core_in_valid   = s_valid & ~blk;
        s_ready         = core_in_ready & ~blk;
        core_in_last    = s_data[DATA_W-1];
        core_in_payload = s_data[DATA_W-2:0];
        s_fire          = s_valid & s_ready;
        push            = s_fire & s_data[DATA_W-1];
        tag_use         = first_beat_q ? s_tag : held_tag_q;
        skid_has_space  = (occ_q != 2'd2);
        core_out_ready  = ~fifo_empty & skid_has_space;
        pop             = core_out_valid & core_out_ready;
        res_data        = {((LAST_FROM_CORE != 0) ? core_out_last : 1'b1), core_out_payload};
        res_tag         = tag_mem_q[rd_ptr_q];
        m_valid         = (occ_q != 2'd0);
        m_data          = head_data_q;
        m_tag           = head_tag_q;
        out_fire        = m_valid & m_ready;
        outstanding     = count_q;
        err_orphan      = err_orphan_q;
    end

    // Next state for tag FIFO, first-beat tracking and orphan flag
    always_comb begin
        tag_mem_d    = tag_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        first_beat_d = first_beat_q;
        held_tag_d   = held_tag_q;
        err_orphan_d = err_orphan_q | (core_out_valid & fifo_empty);
        if (s_fire) begin
            first_beat_d = s_data[DATA_W-1];
            if (first_beat_q) held_tag_d = s_tag;
        end
        if (push) begin
            tag_mem_d[wr_ptr_q] = tag_use;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next state for the skid buffer; pop cannot occur while occ_q == 2
    always_comb begin
        occ_d        = occ_q;
        head_data_d  = head_data_q;
        head_tag_d   = head_tag_q;
        spare_data_d = spare_data_q;
        spare_tag_d  = spare_tag_q;
        case (occ_q)
            2'd0: begin
                if (pop) begin
                    head_data_d = res_data;
                    head_tag_d  = res_tag;
                    occ_d       = 2'd1;
                end
            end
            2'd1: begin
                if (pop && out_fire) begin
                    head_data_d = res_data;
                    head_tag_d  = res_tag;
                end else if (pop) begin
                    spare_data_d = res_data;
                    spare_tag_d  = res_tag;
                    occ_d        = 2'd2;
                end else if (out_fire) begin
                    occ_d = 2'd0;
                end
            end
            default: begin
                if (out_fire) begin
                    head_data_d = spare_data_q;
                    head_tag_d  = spare_tag_q;
                    occ_d       = 2'd1;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            first_beat_q <= 1'b1;
            held_tag_q   <= '0;
            err_orphan_q <= 1'b0;
            occ_q        <= 2'd0;
            head_data_q  <= '0;
            head_tag_q   <= '0;
            spare_data_q <= '0;
            spare_tag_q  <= '0;
        end else begin
            tag_mem_q    <= tag_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            first_beat_q <= first_beat_d;
            held_tag_q   <= held_tag_d;
            err_orphan_q <= err_orphan_d;
            occ_q        <= occ_d;
            head_data_q  <= head_data_d;
            head_tag_q   <= head_tag_d;
            spare_data_q <= spare_data_d;
            spare_tag_q  <= spare_tag_d;
        end
    end

endmodule

// File: doc/poseidon_stream_adapter.md
Name: poseidon_stream_adapter

Overview:
- Parametrised stream adapter between a packed external stream and the Poseidon hash core. The packed stream carries last in its MSB; the core takes last and the field element on separate ports.
- A per-message tag (ID) is captured on the first beat of each input message. It is held in an in-order tag FIFO and reattached to the matching hash result.
- Bounds the number of outstanding messages to DEPTH. Gives a registered, skid-buffered output with no combinational path from m_ready.
- Flags protocol errors: a core result arriving with no pending tag.

Parameters:
- DATA_W, 256, packed stream width; bit DATA_W-1 = last, bits DATA_W-2:0 = field element (FIELD_W = DATA_W-1).
- TAG_W, 8, per-message tag width.
- DEPTH, 4, maximum outstanding messages (tag FIFO entries); power of two, at least 2.
- LAST_FROM_CORE, 0; 0 = m_data MSB forced to 1 on every result, 1 = m_data MSB = core_out_last.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid and s_ready are both 1.
- s_data  in  DATA_W  {last, field element}.
- s_tag  in  TAG_W  message tag; sampled on the first beat of a message only.
- core_in_valid  out  1  to core.
- core_in_ready  in  1  from core.
- core_in_last  out  1  s_data[DATA_W-1].
- core_in_payload  out  FIELD_W  s_data[DATA_W-2:0].
- core_out_valid  in  1  core result valid.
- core_out_ready  out  1  result accepted.
- core_out_last  in  1  core last flag.
- core_out_payload  in  FIELD_W  hash result.
- m_valid  out  1  output valid.
- m_ready  in  1  output accepted.
- m_data  out  DATA_W  {last, hash}.
- m_tag  out  TAG_W  tag of the message this result belongs to.
- outstanding  out  $clog2(DEPTH+1)  tags currently held in the FIFO.
- err_orphan  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (asserted low, asynchronous) puts the block in this state:
  - m_valid=0, skid buffer empty.
  - outstanding=0, FIFO read and write pointers=0.
  - err_orphan=0, first_beat=1, held_tag=0.
  - Any message in flight at reset is discarded. No tag survives reset.
- Input path is combinational and adds no latency:
  - blk = s_data[DATA_W-1] & fifo_full.
  - core_in_valid = s_valid & ~blk.
  - s_ready = core_in_ready & ~blk.
  - Payload and last are driven straight through.
- Tag capture:
  - On an accepted beat with first_beat=1, the tag used is s_tag, otherwise held_tag.
  - held_tag loads s_tag on an accepted first beat.
  - first_beat becomes 1 after an accepted last beat and 0 after any other accepted beat.
  - A single-beat message (first and last together) pushes s_tag directly.
- FIFO push happens on an accepted beat with last=1, writing the tag in use.
- Only last beats stall on full; non-last beats pass while the FIFO is full.
- FIFO pop:
  - core_out_ready = ~fifo_empty & skid_has_space.
  - Pop happens on core_out_valid & core_out_ready.
- Full and empty use registered state only:
  - A push at full is blocked even if a pop happens in the same cycle.
  - A pop while empty is blocked even if a push happens in the same cycle; that tag becomes poppable next cycle.
  - A simultaneous push and pop when not full and not empty leaves outstanding unchanged.
  - Pointers wrap modulo DEPTH.
- Orphan result: when core_out_valid=1 and the FIFO is empty, err_orphan is set on the next edge. core_out_ready stays 0, the result is not consumed, and no output is produced.
- Output is a 2-entry skid buffer:
  - A result accepted at edge N appears on m_valid/m_data/m_tag after edge N; latency 1.
  - Full throughput of 1 result per cycle when m_ready=1.
  - skid_has_space depends on registered occupancy only.
  - m_data = {LAST_FROM_CORE ? core_out_last : 1'b1, core_out_payload}.
  - m_valid, once high, holds with stable data until m_ready=1.
- Ordering: results leave with tags strictly in message-completion order.

Test Plan:
- Single beat {1, 0x5}, s_tag=0x11; core returns 0xAB the next cycle -> m_valid at +1 cycle, m_data = {1, 0xAB}, m_tag=0x11, outstanding goes 1 then 0.
- 3-beat message with s_tag=0x22 on beat 0 and s_tag=0x99 on beats 1 and 2 -> one push, m_tag=0x22; core_in_last=1 only on beat 2.
- DEPTH=4: five single-beat messages with the core stalled -> the 5th stalls with s_ready=0 while outstanding=4. One result popped -> 5th accepted the cycle after; tags 1..5 emerge in order.
- Core result with empty FIFO -> core_out_ready=0, err_orphan=1 the next cycle and stays 1; m_valid stays 0.
- m_ready held 0 for 3 cycles with 3 results pending -> at most 2 buffered, m_data stable, no loss. Release m_ready -> back-to-back output, 1 per cycle.
- reset pulled low mid 3-beat message (after beat 1) -> all outputs at reset values immediately. Next message's first beat uses its own s_tag; LAST_FROM_CORE=1 with core_out_last=0 -> m_data MSB=0.
